// File: rtl/mul_sequencer_if.sv
// EXE-stage <-> shift-add multiplier handshake bundle.
// The master modport is the EXE stage; the slave modport is the multiplier.
`ifndef EXE_MUL
`define EXE_MUL 4'b1010
`endif

interface mul_sequencer_if;
    logic        valid;
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] mul_out;
    logic [3:0]  nzcv;

    modport master (
        output valid, exe_cmd, val1, val2, flush,
        input  stall, done, mul_out, nzcv
    );

    modport slave (
        input  valid, exe_cmd, val1, val2, flush,
        output stall, done, mul_out, nzcv
    );
endinterface

// File: rtl/mul_sequencer.sv
// Sequential shift-add 32x32 multiplier (low 32 bits) with a pipeline stall and a done pulse.
// Optional MUL_SEQUENCER_EARLY_EXIT_EN ends the RUN phase once the remaining multiplier bits are zero.
module mul_sequencer (
    input  logic           clk,
    input  logic           rst,
    mul_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned FLAG_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic [DATA_W-1:0]   r_mul_out;
    logic [FLAG_W-1:0]   r_nzcv;

    logic                w_start;
    logic                w_last;
    logic                w_load;
    logic                w_step;
    logic                w_finish;
    logic                w_stall;
    logic [DATA_W-1:0]   w_acc_sum;
    logic [DATA_W-1:0]   w_mcand_shl;
    logic [DATA_W-1:0]   w_mplier_shr;
    logic [FLAG_W-1:0]   w_nzcv_nxt;

    assign w_start      = bus.valid & (bus.exe_cmd == `EXE_MUL) & ~bus.flush;
    assign w_acc_sum    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mcand_shl  = r_mcand << 1;
    assign w_mplier_shr = r_mplier >> 1;
    assign w_nzcv_nxt   = {w_acc_sum[DATA_W-1], (w_acc_sum == '0), 2'b00};

    // Last RUN edge: fixed 32 steps, or earlier once no multiplier bits remain.
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
    assign w_last = (w_mplier_shr == '0) | (r_cnt == CNT_LAST);
`else
    assign w_last = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush outranks completion; DONE always falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load  = w_start;
                w_stall = w_start;
            end
            S_RUN: begin
                w_stall  = 1'b1;
                w_step   = ~bus.flush;
                w_finish = ~bus.flush & w_last;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_acc    <= '0;
            r_mcand  <= bus.val1;
            r_mplier <= bus.val2;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= w_mcand_shl;
            r_mplier <= w_mplier_shr;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Result and flags are captured only on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_mul_out <= '0;
            r_nzcv    <= '0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_mul_out <= w_acc_sum;
                r_nzcv    <= w_nzcv_nxt;
            end
        end
    end

    assign bus.stall   = w_stall;
    assign bus.done    = r_done;
    assign bus.mul_out = r_mul_out;
    assign bus.nzcv    = r_nzcv;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed table, flush/reset sequences, random operands.
`ifndef EXE_MUL
`define EXE_MUL 4'b1010
`endif

module tb_mul_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_out;
    logic [3:0]  last_nzcv;

    mul_sequencer_if bus ();

    mul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic [3:0]  exp_nzcv;
    } vec_t;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Number of RUN edges: 32 normally; with early exit, the bit length of the multiplier (at least 1).
    function automatic int exp_run_edges(input logic [31:0] b);
        int n;
        logic [31:0] t;
        n = 32;
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
        n = 0;
        t = b;
        while (t != 0) begin
            n++;
            t = t >> 1;
        end
        if (n == 0) n = 1;
`else
        t = b;
`endif
        return n;
    endfunction

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [3:0] exp_nzcv,
                          input string tag);
        int n_stall;
        bit seen;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.exe_cmd = `EXE_MUL;
        bus.val1    = a;
        bus.val2    = b;
        bus.flush   = 1'b0;
        #1;
        n_stall = 0;
        seen    = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall) n_stall++;
            @(negedge clk);
            #1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_stall_cycles"}, 32'(n_stall), 32'(1 + exp_run_edges(b)));
            check({tag, "_stall_in_done"}, 32'(bus.stall), 32'd0);
            check({tag, "_mul_out"}, bus.mul_out, exp_out);
            check({tag, "_nzcv"}, 32'(bus.nzcv), 32'(exp_nzcv));
        end
        bus.valid = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
        check({tag, "_mul_out_hold"}, bus.mul_out, exp_out);
        last_out  = exp_out;
        last_nzcv = exp_nzcv;
    endtask

    vec_t vecs[7];

    initial begin
        bit any_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rp;
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        bus.valid   = 1'b1;
        bus.exe_cmd = `EXE_MUL;
        bus.val1    = 32'd7;
        bus.val2    = 32'd6;
        bus.flush   = 1'b0;

        vecs[0] = '{32'd7,        32'd6,        32'd42,       4'b0000};
        vecs[1] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 4'b1000};
        vecs[2] = '{32'h12345678, 32'd0,        32'd0,        4'b0100};
        vecs[3] = '{32'd3,        32'd5,        32'd15,       4'b0000};
        vecs[4] = '{32'h80000000, 32'd1,        32'h80000000, 4'b1000};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'd0,        4'b0100};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        4'b0000};

        // Reset state, with a MUL request presented during reset.
        #2;
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_mul_out", bus.mul_out, 32'd0);
        check("rst_nzcv", 32'(bus.nzcv), 32'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        bus.valid = 1'b0;

        // Non-MUL command and valid=0 must not start anything.
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.exe_cmd = 4'b0001;
        #1;
        check("idle_nonmul_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.valid   = 1'b0;
        bus.exe_cmd = `EXE_MUL;
        #1;
        check("idle_invalid_stall", 32'(bus.stall), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_mul_out", bus.mul_out, 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_nzcv, $sformatf("vec%0d", i));
        end

        // Flush on the 10th RUN cycle.
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.exe_cmd = `EXE_MUL;
        bus.val1    = 32'd9;
        bus.val2    = 32'd9;
        #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
        end
        check("flush_run_stall", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_idle_stall", 32'(bus.stall), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_mul_out", bus.mul_out, last_out);
        check("flush_nzcv", 32'(bus.nzcv), 32'(last_nzcv));
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            any_done |= bus.done;
        end
        check("flush_no_done", 32'(any_done), 32'd0);

        // Reset pulse mid-RUN.
        @(negedge clk);
        bus.valid = 1'b1;
        bus.val1  = 32'hDEAD0001;
        bus.val2  = 32'hFFFFFFFF;
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_mul_out", bus.mul_out, 32'd0);
        check("midrst_nzcv", 32'(bus.nzcv), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.valid = 1'b0;
        any_done  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            any_done |= bus.done;
        end
        check("midrst_no_done", 32'(any_done), 32'd0);
        check("midrst_hold_out", bus.mul_out, 32'd0);
        do_mul(32'd3, 32'd5, 32'd15, 4'b0000, "post_rst");

        // Random operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 5 == 0) ra = 32'(0) - ra;
            rp = ra * rb;
            do_mul(ra, rb, rp, {rp[31], (rp == 32'd0), 2'b00}, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port valid, input, 1 bit: the EXE stage holds a live instruction.
REQ-004 SHALL have port exe_cmd, input, 4 bits: EXE command; only `EXE_MUL starts a multiply.
REQ-005 SHALL have port val1, input, 32 bits: multiplicand.
REQ-006 SHALL have port val2, input, 32 bits: multiplier.
REQ-007 SHALL have port flush, input, 1 bit: abort any multiply in progress.
REQ-008 SHALL have port stall, output, 1 bit: freezes the pipeline stages upstream of EXE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking the result valid.
REQ-010 SHALL have port mul_out, output, 32 bits: low 32 bits of val1*val2.
REQ-011 SHALL have port nzcv, output, 4 bits: status flags for the result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 start = valid & (exe_cmd == `EXE_MUL) & ~flush; start SHALL be sampled only in IDLE.
REQ-014 The IDLE edge with start SHALL load mcand=val1, mplier=val2, acc=0, cnt=0 and move to RUN.
REQ-015 Each RUN edge SHALL: acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1; cnt += 1 (all arithmetic mod 2^32).
REQ-016 The RUN edge with cnt==31 SHALL move to DONE, giving 32 RUN edges.
REQ-017 Worst-case latency SHALL be: done high in the cycle following the 32nd clock edge after the accepting edge.
REQ-018 In DONE, the FSM SHALL drive done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 A new start SHALL NOT be accepted in DONE.
REQ-020 stall SHALL be combinational: (IDLE & start) | RUN; stall SHALL be 0 in DONE so EXE retires the result.
REQ-021 mul_out SHALL equal acc while done=1 and SHALL hold its last value otherwise.
REQ-022 nzcv SHALL be {mul_out[31], mul_out==0, 1'b0, 1'b0}; C and V SHALL always be 0.
REQ-023 nzcv SHALL update only on the transition into DONE.
REQ-024 flush in RUN or DONE SHALL force IDLE on the next edge, with done=0 and mul_out/nzcv unchanged.
REQ-025 flush SHALL take priority over completion on the same edge.
REQ-026 A non-MUL command or valid=0 in IDLE SHALL leave all state and outputs unchanged.

Reset
REQ-027 rst SHALL asynchronously force state=IDLE and cnt/acc/mcand/mplier=0.
REQ-028 rst SHALL asynchronously force done=0, mul_out=0 and nzcv=0.
REQ-029 stall SHALL evaluate to 0 while rst is high, regardless of other inputs.
REQ-030 rst during RUN SHALL discard the operation; no done pulse SHALL follow.

Configuration
REQ-031 Macro MUL_SEQUENCER_EARLY_EXIT_EN SHALL, when defined, add early termination on a RUN edge.
REQ-032 With MUL_SEQUENCER_EARLY_EXIT_EN defined, the exit condition SHALL be: the shifted mplier becomes 0 or cnt==31.
REQ-033 With MUL_SEQUENCER_EARLY_EXIT_EN defined, val2=0 SHALL exit on the first RUN edge.
REQ-034 With MUL_SEQUENCER_EARLY_EXIT_EN undefined, latency SHALL always be the fixed 32 RUN edges.
REQ-035 Results and flags SHALL be identical in both configurations.

Verification
REQ-036 Bench SHALL cover: val1=7, val2=6, `EXE_MUL -> stall high 33 cycles; then done=1, mul_out=42, nzcv=0000.
REQ-037 Bench SHALL cover: val1=0xFFFFFFFF, val2=2 -> mul_out=0xFFFFFFFE, nzcv=1000.
REQ-038 Bench SHALL cover: val1=0x12345678, val2=0 -> mul_out=0, nzcv=0100.
REQ-039 Bench SHALL cover: flush on the 10th RUN cycle -> IDLE next edge, no done, mul_out keeps its prior value.
REQ-040 Bench SHALL cover: rst pulse mid-RUN -> immediate IDLE, all outputs 0; a following 3*5 request yields 15.
REQ-041 Bench SHALL cover, with MUL_SEQUENCER_EARLY_EXIT_EN: val1=3, val2=5 -> done after 3 RUN edges, mul_out=15.
